// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int          FQ_DEPTH_DEFAULT = 4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // One buffered fetch: the sequential successor PC travels with the word
  // so decode never has to recompute it.
  typedef struct packed {
    logic [31:0] pc_incr;
    logic [31:0] instr;
  } fq_entry_t;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Redirect targets are word addresses; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch front end, instruction memory,
// the MEM-stage redirect source and the decode stage.
interface fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT
);

  logic                         redirect_valid;
  logic [31:0]                  redirect_pc;

  logic [31:0]                  imem_addr;
  logic                         imem_en;
  logic [31:0]                  imem_rdata;

  logic                         id_valid;
  logic                         id_ready;
  logic [31:0]                  id_instr;
  logic [31:0]                  id_pc_incr;

  logic [occ_width(DEPTH)-1:0]  occupancy;

  // Fetch front end side.
  modport master (
    input  redirect_valid,
    input  redirect_pc,
    input  imem_rdata,
    input  id_ready,
    output imem_addr,
    output imem_en,
    output id_valid,
    output id_instr,
    output id_pc_incr,
    output occupancy
  );

  // Environment side: memory, decode and redirect source.
  modport slave (
    output redirect_valid,
    output redirect_pc,
    output imem_rdata,
    output id_ready,
    input  imem_addr,
    input  imem_en,
    input  id_valid,
    input  id_instr,
    input  id_pc_incr,
    input  occupancy
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a single-cycle flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH_DEFAULT,
  localparam int CW    = occ_width(DEPTH),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fq_entry_t     wdata,
  output fq_entry_t     rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fq_entry_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Flush overrides both sides; a push into a full FIFO is only legal
  // when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  assign rdata = mem[rd_ptr];

  // Payload storage; no reset needed because empty gates what is shown.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and count bookkeeping, cleared by reset or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, reads one word per
// cycle from instruction memory and buffers {PC+4, instr} for decode.
//
// Queue state is implied by the occupancy count:
//   state   | meaning
//   EMPTY   | count == 0, nothing offered to decode, outputs forced to 0
//   PARTIAL | 0 < count < DEPTH, fetch and deliver freely
//   FULL    | count == DEPTH, fetch only when decode pops this cycle
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = FQ_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int CW = occ_width(DEPTH);

  logic [31:0]   fpc;
  logic [31:0]   fpc_seq;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  fq_entry_t     head;
  fq_entry_t     tail_entry;

  // Wraps modulo 2^32 by construction.
  assign fpc_seq = fpc + PC_STEP;

  // A redirect kills both sides of the queue for the cycle; id_ready is
  // ignored while it is asserted.
  assign pop  = !empty && bus.id_ready && !bus.redirect_valid;
  assign push = !bus.redirect_valid && (!full || pop);

  assign tail_entry = '{pc_incr: fpc_seq, instr: bus.imem_rdata};

  // Fetch PC: redirect target wins, otherwise step on every accepted fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      fpc <= word_align(bus.redirect_pc);
    end else if (push) begin
      fpc <= fpc_seq;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .wdata (tail_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // The request strobe is held low while reset is asserted so memory sees
  // no fetch until the core is released.
  assign bus.imem_addr  = fpc;
  assign bus.imem_en    = push && rst;

  // No bypass from imem_rdata: decode only ever sees registered entries.
  assign bus.id_valid   = !empty;
  assign bus.id_instr   = empty ? NOP_INSTR : head.instr;
  assign bus.id_pc_incr = empty ? 32'h0 : head.pc_incr;
  assign bus.occupancy  = count;

endmodule
